t2mi_timestamp_tx: RTL and testbench

//  Builds and serialises T2-MI timestamp packets (type 0x20) onto the byte-wide T2-MI stream.

---
 rtl/t2mi_timestamp_tx_pkg.sv | 20 ++
 rtl/t2mi_timestamp_tx_if.sv | 26 ++
 rtl/t2mi_crc32_byte.sv | 20 ++
 rtl/t2mi_timestamp_tx.sv | 166 ++++++++++++++++
 tb/tb_t2mi_timestamp_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t2mi_timestamp_tx_pkg.sv
// T2-MI timestamp transmitter: shared constants, state encoding.
// Imported as t2mi_pkg by the transmitter and the CRC byte engine.
package t2mi_pkg;

    localparam logic [7:0]  T2MI_PKT_TIMESTAMP = 8'h20;
    localparam int          T2MI_HDR_LEN       = 6;
    localparam int          TS_PAYLOAD_LEN     = 11;
    localparam int          T2MI_CRC_LEN       = 4;
    localparam logic [15:0] TS_PAYLOAD_BITS    = 16'd88;
    localparam logic [31:0] CRC32_POLY         = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT         = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_PAY  = 2'd2,
        TX_CRC  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/t2mi_timestamp_tx_if.sv
// Byte-wide T2-MI stream with valid/ready handshake and packet delimiters.
interface t2mi_timestamp_tx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       sop;
    logic       eop;

    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        output ready
    );

endinterface

// File: rtl/t2mi_crc32_byte.sv
// One-byte CRC-32/MPEG-2 step, MSB first, no reflection.
module t2mi_crc32_byte
    import t2mi_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    always_comb begin
        next_crc = crc;
        for (int i = 7; i >= 0; i--) begin
            if (next_crc[31] ^ data[i])
                next_crc = {next_crc[30:0], 1'b0} ^ CRC32_POLY;
            else
                next_crc = {next_crc[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/t2mi_timestamp_tx.sv
// T2-MI timestamp packet (type 0x20) builder/serialiser with CRC-32 trailer.
// Optional T2MI_TX_STATS_EN builds saturating sent/overrun counters.
module t2mi_timestamp_tx
    import t2mi_pkg::*;
#(
    parameter logic [7:0]  PKT_TYPE     = T2MI_PKT_TIMESTAMP,
    parameter logic [15:0] PAYLOAD_BITS = TS_PAYLOAD_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ts_valid,
    input  logic [39:0]         seconds_since_2000,
    input  logic [26:0]         subseconds,
    input  logic [12:0]         utco,
    input  logic [3:0]          bw,
    input  logic [3:0]          superframe_idx,
    t2mi_timestamp_tx_if.master t2mi,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         pkt_sent_cnt,
    output logic [15:0]         overrun_cnt
);

    localparam logic [1:0] S_IDLE = TX_IDLE;
    localparam logic [1:0] S_HDR  = TX_HDR;
    localparam logic [1:0] S_PAY  = TX_PAY;
    localparam logic [1:0] S_CRC  = TX_CRC;

    localparam logic [4:0] HDR_LAST = 5'(T2MI_HDR_LEN - 1);
    localparam logic [4:0] PAY_LAST = 5'(T2MI_HDR_LEN + TS_PAYLOAD_LEN - 1);
    localparam logic [4:0] CRC_LAST =
        5'(T2MI_HDR_LEN + TS_PAYLOAD_LEN + T2MI_CRC_LEN - 1);

    logic [1:0]  state;
    logic [4:0]  byte_idx;
    logic [39:0] sec_q;
    logic [26:0] sub_q;
    logic [12:0] utco_q;
    logic [3:0]  bw_q;
    logic [3:0]  sf_q;
    logic [7:0]  pkt_cnt;
    logic [31:0] crc_q;
    logic [31:0] crc_nxt;
    logic [7:0]  tx_data;
    logic [1:0]  crc_sel;
    logic [0:16][7:0] frame;
    logic        accept;
    logic        last;
    logic        capture;
    logic        ovr_ev;

    assign accept  = t2mi.valid && t2mi.ready;
    assign last    = accept && (state == S_CRC) && (byte_idx == CRC_LAST);
    assign capture = ts_valid && ((state == S_IDLE) || last);
    assign ovr_ev  = ts_valid && busy && !last;

    assign busy       = (state != S_IDLE);
    assign t2mi.valid = busy;
    assign t2mi.sop   = (state == S_HDR) && (byte_idx == 5'd0);
    assign t2mi.eop   = (state == S_CRC) && (byte_idx == CRC_LAST);
    assign t2mi.data  = tx_data;

    // idx 17..20 -> CRC byte 0..3 via two-bit wrap of idx-1
    assign crc_sel = byte_idx[1:0] - 2'd1;

    always_comb begin
        frame = {PKT_TYPE, pkt_cnt, sf_q, 4'h0, 8'h00, PAYLOAD_BITS,
                 4'h0, bw_q, sec_q, sub_q, utco_q};
        tx_data = 8'h00;
        unique case (state)
            S_HDR, S_PAY: tx_data = frame[byte_idx];
            S_CRC: begin
                unique case (crc_sel)
                    2'd0: tx_data = crc_q[31:24];
                    2'd1: tx_data = crc_q[23:16];
                    2'd2: tx_data = crc_q[15:8];
                    2'd3: tx_data = crc_q[7:0];
                endcase
            end
            default: tx_data = 8'h00;
        endcase
    end

    t2mi_crc32_byte u_crc (
        .crc      (crc_q),
        .data     (tx_data),
        .next_crc (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_idx <= '0;
            sec_q    <= '0;
            sub_q    <= '0;
            utco_q   <= '0;
            bw_q     <= '0;
            sf_q     <= '0;
            pkt_cnt  <= '0;
            crc_q    <= CRC32_INIT;
            overrun  <= 1'b0;
        end else begin
            overrun <= ovr_ev;
            if (last)
                pkt_cnt <= pkt_cnt + 8'd1;
            if (capture) begin
                state    <= S_HDR;
                byte_idx <= '0;
                crc_q    <= CRC32_INIT;
                sec_q    <= seconds_since_2000;
                sub_q    <= subseconds;
                utco_q   <= utco;
                bw_q     <= bw;
                sf_q     <= superframe_idx;
            end else begin
                unique case (state)
                    S_IDLE: crc_q <= CRC32_INIT;
                    S_HDR: if (accept) begin
                        byte_idx <= byte_idx + 5'd1;
                        crc_q    <= crc_nxt;
                        if (byte_idx == HDR_LAST)
                            state <= S_PAY;
                    end
                    S_PAY: if (accept) begin
                        byte_idx <= byte_idx + 5'd1;
                        crc_q    <= crc_nxt;
                        if (byte_idx == PAY_LAST)
                            state <= S_CRC;
                    end
                    S_CRC: if (accept) begin
                        if (byte_idx == CRC_LAST) begin
                            state    <= S_IDLE;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef T2MI_TX_STATS_EN
    logic [15:0] sent_q;
    logic [15:0] ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q <= '0;
            ovr_q  <= '0;
        end else begin
            if (last && (sent_q != 16'hFFFF))
                sent_q <= sent_q + 16'd1;
            if (ovr_ev && (ovr_q != 16'hFFFF))
                ovr_q <= ovr_q + 16'd1;
        end
    end

    assign pkt_sent_cnt = sent_q;
    assign overrun_cnt  = ovr_q;
`else
    assign pkt_sent_cnt = 16'd0;
    assign overrun_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_t2mi_timestamp_tx.sv
// Directed bench for t2mi_timestamp_tx: byte map, CRC, stalls, overrun,
// back-to-back capture, mid-packet reset and packet_count wrap.
module tb_t2mi_timestamp_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        ts_valid;
    logic [39:0] seconds_since_2000;
    logic [26:0] subseconds;
    logic [12:0] utco;
    logic [3:0]  bw;
    logic [3:0]  superframe_idx;
    logic        busy;
    logic        overrun;
    logic [15:0] pkt_sent_cnt;
    logic [15:0] overrun_cnt;

    t2mi_timestamp_tx_if tx_if ();

    t2mi_timestamp_tx dut (
        .clk                (clk),
        .rst                (rst),
        .ts_valid           (ts_valid),
        .seconds_since_2000 (seconds_since_2000),
        .subseconds         (subseconds),
        .utco               (utco),
        .bw                 (bw),
        .superframe_idx     (superframe_idx),
        .t2mi               (tx_if.master),
        .busy               (busy),
        .overrun            (overrun),
        .pkt_sent_cnt       (pkt_sent_cnt),
        .overrun_cnt        (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_b[21];
    logic [7:0] t1_hdr[17] = '{8'h20, 8'h00, 8'h30, 8'h00, 8'h00, 8'h58,
                               8'h02, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h00, 8'h00, 8'h00, 8'h20, 8'h12};
    int         checks = 0;
    int         errors = 0;
    bit         rnd_ready = 1'b0;
    bit         stall_prev = 1'b0;
    logic [9:0] prev_out;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'h0};
        for (int k = 0; k < 8; k++)
            r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    task automatic fill_crc();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 17; i++)
            c = crc_step(c, exp_b[i]);
        exp_b[17] = c[31:24];
        exp_b[18] = c[23:16];
        exp_b[19] = c[15:8];
        exp_b[20] = c[7:0];
    endtask

    task automatic build(input logic [7:0] pc, input logic [39:0] sec,
                         input logic [26:0] sub, input logic [12:0] ut,
                         input logic [3:0] bwi, input logic [3:0] sfi);
        logic [135:0] f;
        f = {8'h20, pc, sfi, 4'h0, 8'h00, 16'd88, 4'h0, bwi, sec, sub, ut};
        for (int i = 0; i < 17; i++)
            exp_b[i] = f[135 - 8*i -: 8];
        fill_crc();
    endtask

    // stream monitor: records accepted bytes, checks hold during stalls
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(tx_if.valid), 64'd1);
                chk("hold_out", 64'({tx_if.data, tx_if.sop, tx_if.eop}),
                    64'(prev_out));
            end
            if (tx_if.valid && tx_if.ready)
                rx_q.push_back({tx_if.data, tx_if.sop, tx_if.eop});
            stall_prev = tx_if.valid && !tx_if.ready;
            prev_out   = {tx_if.data, tx_if.sop, tx_if.eop};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tx_if.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic capture(input logic [39:0] sec, input logic [26:0] sub,
                           input logic [12:0] ut, input logic [3:0] bwi,
                           input logic [3:0] sfi);
        seconds_since_2000 = sec;
        subseconds         = sub;
        utco               = ut;
        bw                 = bwi;
        superframe_idx     = sfi;
        ts_valid           = 1'b1;
        tick();
        ts_valid           = 1'b0;
        seconds_since_2000 = 40'hA5A5A5A5A5;
        subseconds         = 27'h5A5A5A5;
        utco               = 13'h1FFF;
        bw                 = 4'hF;
        superframe_idx     = 4'hE;
    endtask

    task automatic wait_bytes(input int n);
        int b;
        b = 0;
        while (rx_q.size() < n && b < 3000) begin
            tick();
            b++;
        end
        if (rx_q.size() < n)
            chk("timeout_bytes", 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_pkt(input string tn, input int base);
        if (rx_q.size() >= base + 21) begin
            for (int i = 0; i < 21; i++) begin
                chk($sformatf("%s_b%0d", tn, i), 64'(rx_q[base+i].d),
                    64'(exp_b[i]));
                chk($sformatf("%s_sop%0d", tn, i), 64'(rx_q[base+i].s),
                    64'(i == 0));
                chk($sformatf("%s_eop%0d", tn, i), 64'(rx_q[base+i].e),
                    64'(i == 20));
            end
        end
    endtask

    initial begin
        string s9;
        logic [31:0] c;
        int b;

        rst = 1'b1;
        ts_valid = 1'b0;
        seconds_since_2000 = '0;
        subseconds = '0;
        utco = '0;
        bw = '0;
        superframe_idx = '0;
        tx_if.ready = 1'b1;

        // reference CRC model against the catalogue check value
        s9 = "123456789";
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++)
            c = crc_step(c, s9[i]);
        chk("crc_model_check", 64'(c), 64'h0376E6E7);

        repeat (3) tick();
        chk("rst_valid", 64'(tx_if.valid), 64'd0);
        chk("rst_sop", 64'(tx_if.sop), 64'd0);
        chk("rst_eop", 64'(tx_if.eop), 64'd0);
        chk("rst_data", 64'(tx_if.data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_sent", 64'(pkt_sent_cnt), 64'd0);
        chk("rst_ovrcnt", 64'(overrun_cnt), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_valid", 64'(tx_if.valid), 64'd0);

        // 1: spec vector, ready always high
        rx_q.delete();
        capture(40'h0012345678, 27'h1, 13'd18, 4'h2, 4'h3);
        chk("t1_lat_valid", 64'(tx_if.valid), 64'd1);
        chk("t1_lat_sop", 64'(tx_if.sop), 64'd1);
        chk("t1_lat_data", 64'(tx_if.data), 64'h20);
        chk("t1_lat_busy", 64'(busy), 64'd1);
        wait_bytes(21);
        for (int i = 0; i < 17; i++)
            exp_b[i] = t1_hdr[i];
        fill_crc();
        check_pkt("t1", 0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // 2: same fields, random ready; packet_count now 1
        rnd_ready = 1'b1;
        rx_q.delete();
        capture(40'h0012345678, 27'h1, 13'd18, 4'h2, 4'h3);
        wait_bytes(21);
        rnd_ready = 1'b0;
        build(8'h01, 40'h0012345678, 27'h1, 13'd18, 4'h2, 4'h3);
        check_pkt("t2", 0);
        tick();

        // 3: ts_valid while byte 10 is on the bus
        rx_q.delete();
        capture(40'hDEADBEEF01, 27'h7ABCDEF, 13'h0ACE, 4'h7, 4'h9);
        wait_bytes(10);
        capture(40'h1111111111, 27'h2222222, 13'h0333, 4'h4, 4'h5);
        chk("t3_ovr_pulse", 64'(overrun), 64'd1);
        tick();
        chk("t3_ovr_clear", 64'(overrun), 64'd0);
        wait_bytes(21);
        build(8'h02, 40'hDEADBEEF01, 27'h7ABCDEF, 13'h0ACE, 4'h7, 4'h9);
        check_pkt("t3", 0);
`ifdef T2MI_TX_STATS_EN
        chk("t3_ovr_cnt", 64'(overrun_cnt), 64'd1);
`else
        chk("t3_ovr_cnt", 64'(overrun_cnt), 64'd0);
`endif
        tick();

        // 5: capture in the same cycle byte 20 is accepted
        rx_q.delete();
        capture(40'h0102030405, 27'h0000100, 13'd37, 4'h1, 4'hC);
        b = 0;
        while (!tx_if.eop && b < 100) begin
            tick();
            b++;
        end
        chk("t5_eop_seen", 64'(tx_if.eop), 64'd1);
        capture(40'hF0E0D0C0B0, 27'h4000000, 13'h1000, 4'h8, 4'h2);
        chk("t5_b2b_valid", 64'(tx_if.valid), 64'd1);
        chk("t5_b2b_sop", 64'(tx_if.sop), 64'd1);
        chk("t5_b2b_data", 64'(tx_if.data), 64'h20);
        chk("t5_b2b_ovr", 64'(overrun), 64'd0);
        wait_bytes(42);
        build(8'h03, 40'h0102030405, 27'h0000100, 13'd37, 4'h1, 4'hC);
        check_pkt("t5a", 0);
        build(8'h04, 40'hF0E0D0C0B0, 27'h4000000, 13'h1000, 4'h8, 4'h2);
        check_pkt("t5b", 21);
        tick();

        // 6: reset while byte 8 is outstanding
        rx_q.delete();
        capture(40'h9999999999, 27'h1234567, 13'h0777, 4'h3, 4'h6);
        wait_bytes(8);
        rst = 1'b1;
        tick();
        chk("t6_valid", 64'(tx_if.valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_eop", 64'(tx_if.eop), 64'd0);
        chk("t6_sent", 64'(pkt_sent_cnt), 64'd0);
        chk("t6_ovrcnt", 64'(overrun_cnt), 64'd0);
        rst = 1'b0;
        rx_q.delete();
        capture(40'h0000000001, 27'h0000002, 13'd3, 4'h4, 4'h5);
        wait_bytes(21);
        build(8'h00, 40'h0000000001, 27'h0000002, 13'd3, 4'h4, 4'h5);
        check_pkt("t6", 0);

        // 4: 256 more packets, packet_count runs 01..FF then wraps to 00
        for (int p = 1; p <= 256; p++) begin
            logic [39:0] sec;
            sec = {8'h00, 32'(p) * 32'h01010101};
            rx_q.delete();
            capture(sec, 27'(p * 7), 13'(p), 4'(p), 4'(p + 1));
            wait_bytes(21);
            build(8'(p), sec, 27'(p * 7), 13'(p), 4'(p), 4'(p + 1));
            check_pkt($sformatf("t4_p%0d", p), 0);
        end
        tick();
`ifdef T2MI_TX_STATS_EN
        chk("t4_sent_cnt", 64'(pkt_sent_cnt), 64'd257);
`else
        chk("t4_sent_cnt", 64'(pkt_sent_cnt), 64'd0);
`endif
        chk("t4_ovr_cnt", 64'(overrun_cnt), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
